// File: rtl/uart_tx.sv
// Single-entry buffered UART transmitter: one byte per valid/ready handshake, shifted out LSB-first.
// Load into the shifter one cycle after acceptance; tx_ready is low while the holding register is full, and offered bytes are dropped (tx_drop).
module uart_tx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115_200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       busy,
  output logic       tx_drop
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] baud_cnt, baud_cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic          stop_idx, stop_idx_nxt;
  logic [7:0]    frame_dat;
  logic [7:0]    hold_dat;
  logic          hold_full;
  logic          txd_nxt;
  logic          load;
  logic          accept;
  logic          bit_end;
  logic          stop_last;
  logic          par_bit;

  // tx_ready is the registered "holding register empty" flag itself.
  assign hold_full = ~tx_ready;
  assign accept    = tx_valid & tx_ready;
  assign bit_end   = (baud_cnt == '0);
  assign stop_last = (STOP_BITS == 2) ? stop_idx : 1'b1;
  assign par_bit   = (PARITY == 2) ? ~^frame_dat : ^frame_dat;
  assign busy      = (state != IDLE) | hold_full;

  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = bit_end ? baud_cnt : baud_cnt - 1'b1;
    bit_idx_nxt  = bit_idx;
    stop_idx_nxt = stop_idx;
    txd_nxt      = txd;
    load         = 1'b0;

    case (state)
      IDLE: begin
        txd_nxt = 1'b1;
        if (hold_full) load = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_nxt    = DATA;
          baud_cnt_nxt = CNT_TOP;
          bit_idx_nxt  = 3'd0;
          txd_nxt      = frame_dat[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_cnt_nxt = CNT_TOP;
          if (bit_idx == 3'd7) begin
            if (PARITY != 0) begin
              state_nxt = PAR;
              txd_nxt   = par_bit;
            end else begin
              state_nxt    = STOP;
              stop_idx_nxt = 1'b0;
              txd_nxt      = 1'b1;
            end
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
            txd_nxt     = frame_dat[bit_idx_nxt];
          end
        end
      end
      PAR: begin
        if (bit_end) begin
          state_nxt    = STOP;
          baud_cnt_nxt = CNT_TOP;
          stop_idx_nxt = 1'b0;
          txd_nxt      = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_last) begin
            // A waiting byte starts immediately so packets go out gap-free.
            if (hold_full) begin
              load = 1'b1;
            end else begin
              state_nxt = IDLE;
              txd_nxt   = 1'b1;
            end
          end else begin
            stop_idx_nxt = 1'b1;
            baud_cnt_nxt = CNT_TOP;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        txd_nxt   = 1'b1;
      end
    endcase

    if (load) begin
      state_nxt    = START;
      baud_cnt_nxt = CNT_TOP;
      bit_idx_nxt  = 3'd0;
      txd_nxt      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= 3'd0;
      stop_idx  <= 1'b0;
      frame_dat <= 8'h00;
      hold_dat  <= 8'h00;
      tx_ready  <= 1'b1;
      txd       <= 1'b1;
      tx_drop   <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      stop_idx <= stop_idx_nxt;
      txd      <= txd_nxt;
      tx_drop  <= tx_valid & ~tx_ready;
      // Accept needs an empty holding register, so it never coincides with load.
      if (load) begin
        frame_dat <= hold_dat;
        tx_ready  <= 1'b1;
      end else if (accept) begin
        hold_dat <= tx_data;
        tx_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances cover DIV=10 8N1, DIV=10 odd parity 2 stop, and DIV=2.
module tb_uart_tx;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [2:0]      vld = '0;
  logic [2:0][7:0] dat = '0;
  logic [2:0]      txd_w, rdy_w, busy_w, drop_w;
  int              n_chk = 0;
  int              n_fail = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .tx_data(dat[0]), .tx_valid(vld[0]),
    .tx_ready(rdy_w[0]), .txd(txd_w[0]), .busy(busy_w[0]), .tx_drop(drop_w[0]));

  uart_tx #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .PARITY(2), .STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst), .tx_data(dat[1]), .tx_valid(vld[1]),
    .tx_ready(rdy_w[1]), .txd(txd_w[1]), .busy(busy_w[1]), .tx_drop(drop_w[1]));

  uart_tx #(.CLK_FREQ(50_000_000), .BAUD(25_000_000), .PARITY(0), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .tx_data(dat[2]), .tx_valid(vld[2]),
    .tx_ready(rdy_w[2]), .txd(txd_w[2]), .busy(busy_w[2]), .tx_drop(drop_w[2]));

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] ones(input int n);
    logic [511:0] m = '0;
    for (int i = 0; i < n; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Expected line level per clock cycle, index 0 = first start-bit cycle.
  function automatic logic [511:0] mkframe(input logic [7:0] b, input int div, input int par, input int stop);
    logic [511:0] v = '0;
    int pos = 0;
    int nb = 9 + ((par != 0) ? 1 : 0) + stop;
    logic bv;
    for (int k = 0; k < nb; k++) begin
      if (k == 0) bv = 1'b0;
      else if (k <= 8) bv = b[k-1];
      else if (par != 0 && k == 9) bv = (par == 2) ? ~^b : ^b;
      else bv = 1'b1;
      for (int c = 0; c < div; c++) begin
        v[pos] = bv;
        pos++;
      end
    end
    return v;
  endfunction

  task automatic send(input int sel, input logic [7:0] b);
    bit ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (rdy_w[sel] && !vld[sel]) ok = 1'b1;
    end
    if (!ok) chk("send_timeout", 512'(0), 512'(1));
    dat[sel] = b;
    vld[sel] = 1'b1;
    @(negedge clk);
    vld[sel] = 1'b0;
  endtask

  task automatic wait_start(input int sel, input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (txd_w[sel] == 1'b0) seen = 1'b1;
    end
    if (!seen) chk("start_timeout", 512'(0), 512'(1));
  endtask

  // First sample is taken at the current negedge.
  task automatic grab(input int sel, input int n, output logic [511:0] tv,
                      output logic [511:0] rv, output logic [511:0] bv);
    tv = '0; rv = '0; bv = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      tv[i] = txd_w[sel];
      rv[i] = rdy_w[sel];
      bv[i] = busy_w[sel];
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] tv, rv, bv, exp;
    logic [9:0]   ctr;
    logic [7:0]   pkt [5];
    int           lows, nrdy;
    pkt = '{8'hFF, 8'h03, 8'h02, 8'h11, 8'h22};

    // Reset held for 3 edges
    repeat (2) @(negedge clk);
    chk("rst_txd",  512'(txd_w[0]),  512'(1'b1));
    chk("rst_rdy",  512'(rdy_w[0]),  512'(1'b1));
    chk("rst_busy", 512'(busy_w[0]), 512'(1'b0));
    chk("rst_drop", 512'(drop_w[0]), 512'(1'b0));
    chk("rst_txd_div2", 512'(txd_w[2]), 512'(1'b1));
    @(negedge clk);
    rst = 1'b0;

    // First byte after reset
    send(0, 8'hA5);
    chk("a5_rdy_low", 512'(rdy_w[0]), 512'(1'b0));
    wait_start(0, 5);
    grab(0, 100, tv, rv, bv);
    chk("a5_frame", tv, mkframe(8'hA5, 10, 0, 1));
    for (int k = 0; k < 10; k++) ctr[k] = tv[10*k+5];
    chk("a5_bits", 512'(ctr), 512'(10'b1101001010));
    chk("a5_rdy_back", rv, ones(100));
    chk("a5_busy", bv, ones(100));
    @(negedge clk);
    chk("a5_idle_busy", 512'(busy_w[0]), 512'(1'b0));
    chk("a5_idle_txd",  512'(txd_w[0]),  512'(1'b1));

    // Encoder-style 5-byte burst
    exp = '0;
    for (int k = 0; k < 5; k++) exp = exp | (mkframe(pkt[k], 10, 0, 1) << (100*k));
    fork
      begin
        for (int k = 0; k < 5; k++) send(0, pkt[k]);
      end
      begin
        wait_start(0, 20);
        grab(0, 500, tv, rv, bv);
      end
    join
    chk("burst_line", tv, exp);
    chk("burst_busy", bv, ones(500));
    @(negedge clk);
    chk("burst_busy_drop", 512'(busy_w[0]), 512'(1'b0));

    // Overrun while a frame is shifting and a byte is held
    fork
      begin
        send(0, 8'h3C);
        send(0, 8'hC3);
        repeat (20) @(negedge clk);
        chk("ovr_full", 512'(rdy_w[0]), 512'(1'b0));
        dat[0] = 8'h99; vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        chk("drop1_on", 512'(drop_w[0]), 512'(1'b1));
        @(negedge clk);
        chk("drop1_off", 512'(drop_w[0]), 512'(1'b0));
        dat[0] = 8'h66; vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        chk("drop2_on", 512'(drop_w[0]), 512'(1'b1));
        @(negedge clk);
        chk("drop2_off", 512'(drop_w[0]), 512'(1'b0));
      end
      begin
        wait_start(0, 20);
        grab(0, 200, tv, rv, bv);
      end
    join
    chk("ovr_line", tv, mkframe(8'h3C, 10, 0, 1) | (mkframe(8'hC3, 10, 0, 1) << 100));
    @(negedge clk);
    chk("ovr_idle", 512'(busy_w[0]), 512'(1'b0));

    // Odd parity, two stop bits
    send(1, 8'h07);
    wait_start(1, 5);
    grab(1, 120, tv, rv, bv);
    chk("par_frame", tv, mkframe(8'h07, 10, 2, 2));
    chk("par_bit", 512'(tv[95]), 512'(1'b0));
    chk("par_stop", 512'(tv[119:100]), 512'(20'hFFFFF));
    chk("par_busy", bv, ones(120));
    @(negedge clk);
    chk("par_len", 512'(busy_w[1]), 512'(1'b0));

    // Minimum divider
    send(2, 8'h55);
    wait_start(2, 5);
    grab(2, 20, tv, rv, bv);
    chk("div2_frame", tv, mkframe(8'h55, 2, 0, 1));
    chk("div2_hand", 512'(tv[19:0]), 512'(20'hCCCCC));
    @(negedge clk);
    chk("div2_len", 512'(busy_w[2]), 512'(1'b0));

    // Reset during data bit 3 of 0x00
    send(0, 8'h00);
    wait_start(0, 5);
    repeat (44) @(negedge clk);
    chk("mid_bit3_low", 512'(txd_w[0]), 512'(1'b0));
    rst = 1'b1;
    #1;
    chk("mid_async_txd", 512'(txd_w[0]), 512'(1'b1));
    chk("mid_async_rdy", 512'(rdy_w[0]), 512'(1'b1));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lows = 0;
    nrdy = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (txd_w[0] == 1'b0) lows++;
      if (rdy_w[0] != 1'b1) nrdy++;
    end
    chk("mid_no_residual", 512'(lows), 512'(0));
    chk("mid_rdy_idle", 512'(nrdy), 512'(0));
    chk("mid_busy", 512'(busy_w[0]), 512'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
